clkdiv_reset_sequencer: RTL and testbench

CLKDIV_RESET_SEQUENCER -- requirements
Module: clkdiv_reset_sequencer

---
 rtl/clkdiv_seq_pkg.sv | 22 ++
 rtl/clkdiv_reset_sequencer_if.sv | 31 +++
 rtl/clkdiv_lock_filter.sv | 42 ++++
 rtl/clkdiv_reset_sequencer.sv | 124 ++++++++++++
 tb/tb_clkdiv_reset_sequencer.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/clkdiv_seq_pkg.sv
// Shared types and default timing constants for the divider reset sequencer.
// Latency: n/a (declarations only). Backpressure: n/a.
// Optional watchdog is selected per build with CLKDIV_SEQ_WATCHDOG_EN.
package clkdiv_seq_pkg;

    localparam int LOCK_FILTER_DEF   = 16;
    localparam int SETTLE_CYCLES_DEF = 8;
    localparam int WDOG_CYCLES_DEF   = 65535;

    typedef enum logic [1:0] {
        ST_HOLD,
        ST_RELEASE,
        ST_SETTLE,
        ST_RUN
    } state_t;

    // Bits needed to hold values 0..n inclusive, never less than one.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/clkdiv_reset_sequencer_if.sv
// Lock/restart inputs and divider-control outputs of the reset sequencer.
// Latency: n/a (wiring only). Backpressure: none, all signals are level/pulse.
// Sequencer side uses the slave modport, the surrounding logic uses master.
interface clkdiv_reset_sequencer_if;

    logic       pll_lock;
    logic       restart_req;
    logic       div_resetn;
    logic       div_ready;
    logic       fault;
    logic [7:0] loss_cnt;

    modport master (
        output pll_lock,
        output restart_req,
        input  div_resetn,
        input  div_ready,
        input  fault,
        input  loss_cnt
    );

    modport slave (
        input  pll_lock,
        input  restart_req,
        output div_resetn,
        output div_ready,
        output fault,
        output loss_cnt
    );

endinterface

// File: rtl/clkdiv_lock_filter.sv
// Synchronises the async PLL lock and qualifies it over LOCK_FILTER steady cycles.
// Latency: lock_s 2 cycles after pll_lock, lock_ok LOCK_FILTER cycles after lock_s.
// Backpressure: none; clear restarts qualification from zero.
module clkdiv_lock_filter
    import clkdiv_seq_pkg::*;
#(
    parameter int LOCK_FILTER = LOCK_FILTER_DEF
) (
    input  logic hclkin,
    input  logic resetn,
    input  logic lock_async,
    input  logic clear,
    output logic lock_s,
    output logic lock_ok
);

    localparam int            CW      = cnt_width(LOCK_FILTER);
    localparam logic [CW-1:0] CNT_MAX = CW'(LOCK_FILTER);

    logic          lock_meta;
    logic [CW-1:0] cnt;

    always_ff @(posedge hclkin or negedge resetn) begin
        if (!resetn) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
            cnt       <= '0;
        end else begin
            lock_meta <= lock_async;
            lock_s    <= lock_meta;
            // Any low sample or explicit clear forces a full re-qualification.
            if (clear || !lock_s) begin
                cnt <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    assign lock_ok = (cnt == CNT_MAX);

endmodule

// File: rtl/clkdiv_reset_sequencer.sv
// Sequences CLKDIV2 reset release after qualified PLL lock; optional watchdog via CLKDIV_SEQ_WATCHDOG_EN.
// Latency: div_resetn 19 cycles after lock rise (defaults), div_ready SETTLE_CYCLES+1 later.
// Backpressure: none; lock loss or restart_req drops back to HOLD on the next edge.
module clkdiv_reset_sequencer
    import clkdiv_seq_pkg::*;
#(
    parameter int LOCK_FILTER   = LOCK_FILTER_DEF,
    parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF,
    parameter int WDOG_CYCLES   = WDOG_CYCLES_DEF
) (
    input  logic                     hclkin,
    input  logic                     resetn,
    clkdiv_reset_sequencer_if.slave  bus
);

    localparam int            SW          = cnt_width(SETTLE_CYCLES);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [7:0]    LOSS_MAX    = 8'hFF;

    logic          lock_s;
    logic          lock_ok;
    state_t        state;
    state_t        state_nxt;
    logic          loss_evt;
    logic [SW-1:0] settle_cnt;
    logic          div_resetn_r;
    logic          div_ready_r;
    logic [7:0]    loss_cnt_r;

    clkdiv_lock_filter #(
        .LOCK_FILTER (LOCK_FILTER)
    ) u_lock_filter (
        .hclkin     (hclkin),
        .resetn     (resetn),
        .lock_async (bus.pll_lock),
        .clear      (bus.restart_req),
        .lock_s     (lock_s),
        .lock_ok    (lock_ok)
    );

    // A lock drop takes precedence over a simultaneous restart so it is still counted.
    always_comb begin
        state_nxt = state;
        loss_evt  = 1'b0;
        case (state)
            ST_HOLD: begin
                if (lock_ok && !bus.restart_req) state_nxt = ST_RELEASE;
            end
            ST_RELEASE: begin
                if (!lock_s || bus.restart_req) state_nxt = ST_HOLD;
                else                            state_nxt = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (!lock_s || bus.restart_req)    state_nxt = ST_HOLD;
                else if (settle_cnt == SETTLE_LAST) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (!lock_s || bus.restart_req) state_nxt = ST_HOLD;
                loss_evt = !lock_s;
            end
            default: state_nxt = ST_HOLD;
        endcase
    end

    always_ff @(posedge hclkin or negedge resetn) begin
        if (!resetn) begin
            state        <= ST_HOLD;
            settle_cnt   <= '0;
            div_resetn_r <= 1'b0;
            div_ready_r  <= 1'b0;
            loss_cnt_r   <= '0;
        end else begin
            state        <= state_nxt;
            div_resetn_r <= (state_nxt != ST_HOLD);
            div_ready_r  <= (state_nxt == ST_RUN);
            if (state == ST_SETTLE && state_nxt == ST_SETTLE) begin
                settle_cnt <= settle_cnt + SW'(1);
            end else begin
                settle_cnt <= '0;
            end
            if (loss_evt && loss_cnt_r != LOSS_MAX) begin
                loss_cnt_r <= loss_cnt_r + 8'd1;
            end
        end
    end

    assign bus.div_resetn = div_resetn_r;
    assign bus.div_ready  = div_ready_r;
    assign bus.loss_cnt   = loss_cnt_r;

`ifdef CLKDIV_SEQ_WATCHDOG_EN
    localparam int            WW      = cnt_width(WDOG_CYCLES);
    localparam logic [WW-1:0] WD_MAX  = WW'(WDOG_CYCLES);
    localparam logic [WW-1:0] WD_LAST = WW'(WDOG_CYCLES - 1);

    logic [WW-1:0] wd_cnt;
    logic          fault_r;

    // Timeout only flags; the FSM keeps waiting in HOLD for lock.
    always_ff @(posedge hclkin or negedge resetn) begin
        if (!resetn) begin
            wd_cnt  <= '0;
            fault_r <= 1'b0;
        end else if (bus.restart_req) begin
            wd_cnt  <= '0;
            fault_r <= 1'b0;
        end else if (state == ST_HOLD) begin
            if (wd_cnt != WD_MAX) wd_cnt <= wd_cnt + WW'(1);
            if (wd_cnt == WD_LAST) fault_r <= 1'b1;
        end else begin
            wd_cnt <= '0;
        end
    end

    assign bus.fault = fault_r;
`else
    // WDOG_CYCLES only has meaning when the watchdog is built in.
    if (WDOG_CYCLES < 1) begin : g_wdog_cfg_unused
    end

    assign bus.fault = 1'b0;
`endif

endmodule

// File: tb/tb_clkdiv_reset_sequencer.sv
// Directed bench for clkdiv_reset_sequencer: release timing, lock glitches, loss counting, restart, watchdog.
// Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
module tb_clkdiv_reset_sequencer;

    logic hclkin = 1'b0;
    logic resetn = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    clkdiv_reset_sequencer_if bus ();

    clkdiv_reset_sequencer #(
        .LOCK_FILTER   (16),
        .SETTLE_CYCLES (8),
        .WDOG_CYCLES   (100)
    ) dut (
        .hclkin (hclkin),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 hclkin = ~hclkin;

    task automatic tick();
        @(posedge hclkin);
        #1;
    endtask

    task automatic do_reset(input logic lock_val);
        resetn          = 1'b0;
        bus.pll_lock    = lock_val;
        bus.restart_req = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
    endtask

    task automatic go_run();
        do_reset(1'b1);
        repeat (28) tick();
    endtask

    task automatic test_reset();
        resetn          = 1'b0;
        bus.pll_lock    = 1'b1;
        bus.restart_req = 1'b0;
        tick();
        n_tests++;
        if (bus.div_resetn !== 1'b0) begin n_fail++; $display("FAIL reset_div_resetn: got %b expected 0", bus.div_resetn); end
        n_tests++;
        if (bus.div_ready !== 1'b0) begin n_fail++; $display("FAIL reset_div_ready: got %b expected 0", bus.div_ready); end
        n_tests++;
        if (bus.fault !== 1'b0) begin n_fail++; $display("FAIL reset_fault: got %b expected 0", bus.fault); end
        n_tests++;
        if (bus.loss_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_loss_cnt: got %0d expected 0", bus.loss_cnt); end
        tick();
        resetn = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            tick();
            n_tests++;
            if (bus.div_resetn !== (k >= 19)) begin
                n_fail++; $display("FAIL startup_div_resetn cycle %0d: got %b expected %b", k, bus.div_resetn, (k >= 19));
            end
            n_tests++;
            if (bus.div_ready !== (k >= 28)) begin
                n_fail++; $display("FAIL startup_div_ready cycle %0d: got %b expected %b", k, bus.div_ready, (k >= 28));
            end
        end
        n_tests++;
        if (bus.loss_cnt !== 8'd0) begin n_fail++; $display("FAIL startup_loss_cnt: got %0d expected 0", bus.loss_cnt); end
        n_tests++;
        if (bus.fault !== 1'b0) begin n_fail++; $display("FAIL startup_fault: got %b expected 0", bus.fault); end
        // Reset mid-cycle must clear the outputs without waiting for an edge.
        #2;
        resetn = 1'b0;
        #1;
        n_tests++;
        if (bus.div_resetn !== 1'b0 || bus.div_ready !== 1'b0) begin
            n_fail++; $display("FAIL async_reset: got resetn=%b ready=%b expected 0 0", bus.div_resetn, bus.div_ready);
        end
        tick();
        resetn = 1'b1;
    endtask

    task automatic test_reset_midlock();
        do_reset(1'b1);
        repeat (10) tick();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        for (int k = 1; k <= 19; k++) begin
            tick();
            n_tests++;
            if (bus.div_resetn !== (k == 19)) begin
                n_fail++; $display("FAIL midlock_requalify cycle %0d: got %b expected %b", k, bus.div_resetn, (k == 19));
            end
        end
    endtask

    task automatic test_lock_glitch();
        do_reset(1'b0);
        repeat (3) tick();
        bus.pll_lock = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            n_tests++;
            if (bus.div_resetn !== 1'b0) begin n_fail++; $display("FAIL glitch_high cycle %0d: got %b expected 0", k, bus.div_resetn); end
        end
        bus.pll_lock = 1'b0;
        tick();
        n_tests++;
        if (bus.div_resetn !== 1'b0) begin n_fail++; $display("FAIL glitch_low: got %b expected 0", bus.div_resetn); end
        bus.pll_lock = 1'b1;
        for (int k = 1; k <= 19; k++) begin
            tick();
            n_tests++;
            if (bus.div_resetn !== (k == 19)) begin
                n_fail++; $display("FAIL glitch_release cycle %0d: got %b expected %b", k, bus.div_resetn, (k == 19));
            end
        end
    endtask

    task automatic test_restart();
        go_run();
        bus.restart_req = 1'b1;
        tick();
        bus.restart_req = 1'b0;
        n_tests++;
        if (bus.div_resetn !== 1'b0 || bus.div_ready !== 1'b0) begin
            n_fail++; $display("FAIL restart_hold: got resetn=%b ready=%b expected 0 0", bus.div_resetn, bus.div_ready);
        end
        for (int k = 1; k <= 17; k++) begin
            tick();
            n_tests++;
            if (bus.div_resetn !== (k == 17)) begin
                n_fail++; $display("FAIL restart_rerelease cycle %0d: got %b expected %b", k, bus.div_resetn, (k == 17));
            end
        end
        n_tests++;
        if (bus.loss_cnt !== 8'd0) begin n_fail++; $display("FAIL restart_loss_cnt: got %0d expected 0", bus.loss_cnt); end
    endtask

    task automatic test_drop_settle();
        do_reset(1'b1);
        repeat (22) tick();
        bus.pll_lock = 1'b0;
        repeat (3) tick();
        n_tests++;
        if (bus.div_resetn !== 1'b0 || bus.div_ready !== 1'b0) begin
            n_fail++; $display("FAIL settle_drop: got resetn=%b ready=%b expected 0 0", bus.div_resetn, bus.div_ready);
        end
        n_tests++;
        if (bus.loss_cnt !== 8'd0) begin n_fail++; $display("FAIL settle_drop_loss_cnt: got %0d expected 0", bus.loss_cnt); end
    endtask

    // restart_req is raised in the cycle the synchronised lock is already low.
    task automatic test_drop_with_restart();
        go_run();
        bus.pll_lock = 1'b0;
        tick();
        tick();
        bus.restart_req = 1'b1;
        tick();
        bus.restart_req = 1'b0;
        n_tests++;
        if (bus.div_resetn !== 1'b0) begin n_fail++; $display("FAIL drop_restart_hold: got %b expected 0", bus.div_resetn); end
        n_tests++;
        if (bus.loss_cnt !== 8'd1) begin n_fail++; $display("FAIL drop_restart_loss_cnt: got %0d expected 1", bus.loss_cnt); end
    endtask

    task automatic test_lock_loss();
        go_run();
        for (int i = 0; i < 300; i++) begin
            int exp_loss;
            exp_loss = (i + 1 > 255) ? 255 : i + 1;
            bus.pll_lock = 1'b0;
            tick();
            tick();
            n_tests++;
            if (bus.div_resetn !== 1'b1) begin n_fail++; $display("FAIL loss_early drop %0d: got %b expected 1", i, bus.div_resetn); end
            tick();
            n_tests++;
            if (bus.div_resetn !== 1'b0) begin n_fail++; $display("FAIL loss_hold drop %0d: got %b expected 0", i, bus.div_resetn); end
            n_tests++;
            if (bus.loss_cnt !== 8'(exp_loss)) begin
                n_fail++; $display("FAIL loss_cnt drop %0d: got %0d expected %0d", i, bus.loss_cnt, exp_loss);
            end
            bus.pll_lock = 1'b1;
            repeat (28) tick();
            n_tests++;
            if (bus.div_ready !== 1'b1) begin n_fail++; $display("FAIL loss_rerun drop %0d: got %b expected 1", i, bus.div_ready); end
        end
    endtask

    task automatic test_watchdog();
        do_reset(1'b0);
`ifdef CLKDIV_SEQ_WATCHDOG_EN
        for (int k = 1; k <= 105; k++) begin
            tick();
            n_tests++;
            if (bus.fault !== (k >= 100)) begin
                n_fail++; $display("FAIL wdog_timeout cycle %0d: got %b expected %b", k, bus.fault, (k >= 100));
            end
        end
        bus.pll_lock = 1'b1;
        for (int k = 1; k <= 19; k++) begin
            tick();
            n_tests++;
            if (bus.div_resetn !== (k == 19)) begin
                n_fail++; $display("FAIL wdog_release cycle %0d: got %b expected %b", k, bus.div_resetn, (k == 19));
            end
        end
        n_tests++;
        if (bus.fault !== 1'b1) begin n_fail++; $display("FAIL wdog_sticky: got %b expected 1", bus.fault); end
        bus.restart_req = 1'b1;
        tick();
        bus.restart_req = 1'b0;
        n_tests++;
        if (bus.fault !== 1'b0) begin n_fail++; $display("FAIL wdog_clear: got %b expected 0", bus.fault); end
`else
        for (int k = 1; k <= 150; k++) begin
            tick();
            n_tests++;
            if (bus.fault !== 1'b0) begin n_fail++; $display("FAIL no_wdog_fault cycle %0d: got %b expected 0", k, bus.fault); end
        end
        bus.restart_req = 1'b1;
        tick();
        bus.restart_req = 1'b0;
        n_tests++;
        if (bus.fault !== 1'b0) begin n_fail++; $display("FAIL no_wdog_restart: got %b expected 0", bus.fault); end
`endif
    endtask

    initial begin
        bus.pll_lock    = 1'b0;
        bus.restart_req = 1'b0;
        test_reset();
        test_reset_midlock();
        test_lock_glitch();
        test_restart();
        test_drop_settle();
        test_drop_with_restart();
        test_lock_loss();
        test_watchdog();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
